// File: rtl/bf_pkg.sv
// Shared Blowfish S-box definitions: word/index widths, table depth and loader FSM states.
package bf_pkg;

  localparam int BF_WORD_W     = 32;
  localparam int BF_IDX_W      = 8;
  localparam int BF_SBOX_DEPTH = 256;

  typedef logic [BF_WORD_W-1:0] bf_word_t;
  typedef logic [BF_IDX_W-1:0]  bf_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } bf_load_state_e;

endpackage

// File: rtl/bf_sbox_ram.sv
// DEPTH x DATA_W S-box RAM: one synchronous write port and one registered read port.
// Define BF_SBOX_WR_BYPASS_EN to forward same-cycle write data to a colliding read.
module bf_sbox_ram
  import bf_pkg::*;
#(
  parameter int DEPTH  = BF_SBOX_DEPTH,
  parameter int DATA_W = BF_WORD_W,
  parameter int IDX_W  = BF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  // Table contents are deliberately not reset so the array maps onto plain RAM.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef BF_SBOX_WR_BYPASS_EN
  assign rd_word = (we && (waddr == raddr)) ? wdata : mem[raddr];
`else
  assign rd_word = mem[raddr];
`endif

  // rdata holds its last value between reads; rvalid marks the cycle after re.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= rd_word;
      end
    end
  end

endmodule

// File: rtl/bf_sbox_loader.sv
// Blowfish S-box loader: streams key-expansion words into the S-box RAM in index order
// and serves registered F-function lookups. Optional macro: BF_SBOX_WR_BYPASS_EN.
module bf_sbox_loader
  import bf_pkg::*;
#(
  parameter int DEPTH  = BF_SBOX_DEPTH,
  parameter int DATA_W = BF_WORD_W,
  parameter int IDX_W  = BF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [IDX_W-1:0]  wr_idx,
  output logic              busy,
  output logic              done,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output bf_load_state_e    state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Handshake: a word transfers on a rising edge where wr_valid && wr_ready are both high;
  // wr_valid may be held low any number of cycles, wr_ready is high exactly while in LOAD.
  logic xfer;

  assign wr_ready = (state == LOAD);
  assign xfer     = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_idx <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= LOAD;
            wr_idx <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end
        LOAD: begin
          // start is ignored here: a running load is never restarted.
          if (xfer) begin
            wr_idx <= wr_idx + IDX_W'(1);
            if (wr_idx == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          wr_idx <= '0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  bf_sbox_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (xfer),
    .waddr  (wr_idx),
    .wdata  (wr_data),
    .re     (rd_en),
    .raddr  (rd_addr),
    .rdata  (rd_data),
    .rvalid (rd_valid)
  );

endmodule

// File: tb/tb_bf_sbox_loader.sv
// Self-checking bench for bf_sbox_loader against a behavioural table/counter model.
module tb_bf_sbox_loader;
  import bf_pkg::*;

  localparam int DEPTH = 256;
`ifdef BF_SBOX_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [7:0]  wr_idx;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  bf_load_state_e state;

  bf_sbox_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .wr_idx   (wr_idx),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .state    (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: table contents, load progress, read result
  logic [31:0] ref_mem [DEPTH];
  bit          m_loading;
  int          m_count;
  bit          m_done;
  bit          m_rd_valid;
  logic [31:0] m_rd_data;

  task automatic model_reset();
    m_loading  = 1'b0;
    m_count    = 0;
    m_done     = 1'b0;
    m_rd_valid = 1'b0;
    m_rd_data  = 32'h0;
  endtask

  // advance one rising edge with the currently driven inputs, updating the model
  task automatic tick();
    bit x;
    x = m_loading && wr_valid;
    if (rd_en) begin
      m_rd_valid = 1'b1;
      m_rd_data  = (BYPASS && x && (m_count == int'(rd_addr))) ? wr_data : ref_mem[rd_addr];
    end else begin
      m_rd_valid = 1'b0;
    end
    if (x) begin
      ref_mem[m_count] = wr_data;
      m_count++;
      if (m_count == DEPTH) begin
        m_loading = 1'b0;
        m_done    = 1'b1;
        m_count   = 0;
      end
    end else if (start && !m_loading) begin
      m_loading = 1'b1;
      m_count   = 0;
      m_done    = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 32'h0;
    rd_en    = 1'b0;
    rd_addr  = 8'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({wr_ready, busy, done, rd_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b exp 0000", {wr_ready, busy, done, rd_valid});
    end
    n_checks++;
    if (wr_idx !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_wr_idx: got %h exp 00", wr_idx);
    end
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h exp 00000000", rd_data);
    end
    n_checks++;
    if (state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d exp %0d", state, IDLE);
    end
  endtask

  task automatic test_full_load();
    int k;
    logic [31:0] exp_c [3];
    logic [7:0]  addrs [3];
    pulse_start();
    for (k = 1; k <= 300; k++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(m_count);
      tick();
      n_checks++;
      if ({wr_ready, busy, done, wr_idx} !== {m_loading, m_loading, m_done, 8'(m_count)}) begin
        n_fail++;
        $display("FAIL full_load_step%0d: got rdy/busy/done/idx %b%b%b/%h exp %b%b%b/%h",
                 k, wr_ready, busy, done, wr_idx, m_loading, m_loading, m_done, 8'(m_count));
      end
      if (done === 1'b1) break;
    end
    wr_valid = 1'b0;
    n_checks++;
    if (k !== 256) begin
      n_fail++;
      $display("FAIL full_load_latency: got %0d cycles exp 256", k);
    end
    addrs[0] = 8'd0;  exp_c[0] = 32'h00000000;
    addrs[1] = 8'd1;  exp_c[1] = 32'h00000001;
    addrs[2] = 8'd255; exp_c[2] = 32'h000000FF;
    for (int i = 0; i < 3; i++) begin
      rd_en   = 1'b1;
      rd_addr = addrs[i];
      tick();
      rd_en = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_c[i]) begin
        n_fail++;
        $display("FAIL full_load_read%0d: got v=%b %h exp v=1 %h", addrs[i], rd_valid, rd_data, exp_c[i]);
      end
    end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== exp_c[2]) begin
      n_fail++;
      $display("FAIL read_hold: got v=%b %h exp v=0 %h", rd_valid, rd_data, exp_c[2]);
    end
  endtask

  task automatic test_backpressure();
    int k;
    pulse_start();
    for (k = 1; k <= 600; k++) begin
      wr_valid = (k % 2 == 0);
      wr_data  = $urandom;
      tick();
      n_checks++;
      if ({busy, done, wr_idx} !== {m_loading, m_done, 8'(m_count)}) begin
        n_fail++;
        $display("FAIL bp_step%0d: got busy/done/idx %b%b/%h exp %b%b/%h",
                 k, busy, done, wr_idx, m_loading, m_done, 8'(m_count));
      end
      if (done === 1'b1) break;
    end
    wr_valid = 1'b0;
    n_checks++;
    if (k !== 512) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d cycles exp 512", k);
    end
  endtask

  task automatic test_back_to_back_reads();
    rd_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rd_addr = 8'($urandom_range(0, DEPTH - 1));
      tick();
      n_checks++;
      if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin
        n_fail++;
        $display("FAIL b2b_read%0d: got v=%b %h exp v=%b %h", i, rd_valid, rd_data, m_rd_valid, m_rd_data);
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_ignored_restart();
    int  n_xfer;
    bit  pulsed;
    int  k;
    n_xfer = 0;
    pulsed = 1'b0;
    pulse_start();
    for (k = 0; k < 2000; k++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = $urandom;
      start    = (m_count == 100) && !pulsed;
      if (start) pulsed = 1'b1;
      if (wr_valid && m_loading) n_xfer++;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, done, wr_idx} !== {m_loading, m_done, 8'(m_count)}) begin
        n_fail++;
        $display("FAIL restart_step%0d: got busy/done/idx %b%b/%h exp %b%b/%h",
                 k, busy, done, wr_idx, m_loading, m_done, 8'(m_count));
      end
      if (done === 1'b1) break;
    end
    wr_valid = 1'b0;
    n_checks++;
    if (n_xfer !== 256 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_total: got %0d transfers done=%b exp 256 done=1", n_xfer, done);
    end
  endtask

  task automatic test_reset_mid_load();
    int k;
    pulse_start();
    for (k = 0; k < 400 && m_count != 50; k++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_data  = $urandom;
      tick();
    end
    wr_valid = 1'b0;
    n_checks++;
    if (wr_idx !== 8'd50) begin
      n_fail++;
      $display("FAIL midreset_reach: got idx %h exp 32", wr_idx);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({wr_ready, busy, done, rd_valid, wr_idx, rd_data} !== {4'b0000, 8'h00, 32'h0} || state !== IDLE) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rdy/busy/done/rv %b%b%b%b idx %h rd %h st %0d exp 0000 00 0 IDLE",
               wr_ready, busy, done, rd_valid, wr_idx, rd_data, state);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    // reload with the identity pattern from index 0
    pulse_start();
    n_checks++;
    if (wr_idx !== 8'h00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_restart: got idx %h busy %b exp 00 1", wr_idx, busy);
    end
    for (k = 0; k < 300 && m_loading; k++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(m_count);
      tick();
    end
    wr_valid = 1'b0;
    n_checks++;
    if (done !== 1'b1 || k !== 256) begin
      n_fail++;
      $display("FAIL midreset_reload: got done=%b after %0d exp done=1 after 256", done, k);
    end
  endtask

  task automatic test_collision();
    int k;
    logic [31:0] exp_c;
    pulse_start();
    for (k = 0; k < 7; k++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(m_count);
      tick();
    end
    wr_data = 32'hDEADBEEF;
    rd_en   = 1'b1;
    rd_addr = 8'd7;
    tick();
    rd_en = 1'b0;
    exp_c = BYPASS ? 32'hDEADBEEF : 32'h00000007;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_c) begin
      n_fail++;
      $display("FAIL collision_read: got v=%b %h exp v=1 %h", rd_valid, rd_data, exp_c);
    end
    wr_valid = 1'b0;
    rd_en    = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL collision_after: got %h exp deadbeef", rd_data);
    end
    for (k = 0; k < 300 && m_loading; k++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(m_count);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reload_from_done();
    int k;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_pre_done: got %b exp 1", done);
    end
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || state !== LOAD) begin
      n_fail++;
      $display("FAIL reload_clear: got done=%b busy=%b st=%0d exp 0 1 LOAD", done, busy, state);
    end
    for (k = 1; k <= 300; k++) begin
      wr_valid = 1'b1;
      wr_data  = ~32'(m_count);
      tick();
      if (done === 1'b1) break;
    end
    wr_valid = 1'b0;
    n_checks++;
    if (k !== 256 || state !== DONE) begin
      n_fail++;
      $display("FAIL reload_done: got %0d cycles st=%0d exp 256 DONE", k, state);
    end
    rd_en   = 1'b1;
    rd_addr = 8'd3;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hFFFFFFFC) begin
      n_fail++;
      $display("FAIL reload_read3: got v=%b %h exp v=1 fffffffc", rd_valid, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_back_to_back_reads();
    test_backpressure();
    test_back_to_back_reads();
    test_ignored_restart();
    test_back_to_back_reads();
    test_reset_mid_load();
    test_collision();
    test_reload_from_done();
    test_back_to_back_reads();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bf_sbox_loader.md
# bf_sbox_loader

Writer side of the Blowfish S-box path: accepts a stream of 32-bit words during key expansion and writes them in index order into a 256×32 S-box RAM. It also serves registered reads to the F-function. It sits between the key-schedule sequencer, which produces words, and the round datapath, which consumes lookups. Reads use an 8-bit index and return a 32-bit word, so the same access pattern serves the fixed-table lookup.

## Interface
- DEPTH, 256, number of S-box entries (power of two)
- DATA_W, 32, entry width
- IDX_W, 8, index width, equal to log2(DEPTH)

- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a full table load
- wr_valid  in  1  wr_data is valid
- wr_data  in  DATA_W  next entry to write
- wr_ready  out  1  loader accepts a word this cycle
- wr_idx  out  IDX_W  index the next accepted word is written to
- busy  out  1  a load is in progress
- done  out  1  last load completed; held until the next start or reset
- rd_en  in  1  read request
- rd_addr  in  IDX_W  read index
- rd_data  out  DATA_W  read result
- rd_valid  out  1  rd_data is valid this cycle

## Operation
- FSM states are IDLE, LOAD and DONE.
- IDLE → LOAD on start. In the same edge: wr_idx ← 0 and done ← 0.
- LOAD: wr_ready = 1 (combinational from state). A transfer occurs when wr_valid && wr_ready. On a transfer, mem[wr_idx] ← wr_data and wr_idx ← wr_idx + 1.
- LOAD → DONE on the transfer at wr_idx == DEPTH−1. wr_idx wraps to 0, done ← 1, busy ← 0.
- DONE → LOAD on start, which restarts the load. In IDLE and DONE, wr_ready = 0.
- start during LOAD is ignored. The load is not restarted and the counter is not reset.
- wr_valid low in LOAD stalls the load indefinitely. No timeout.
- Read port is independent of the FSM. rd_en in cycle N gives rd_data = mem[rd_addr] and rd_valid = 1 in cycle N+1. Otherwise rd_valid = 0 and rd_data holds its last value.
- Read and write to the same index in the same cycle returns the old data, unless the write-bypass feature is compiled in (see Configuration).
- RAM contents are not reset. Reads of entries not yet written return undefined data.
- Reset values: wr_ready 0, wr_idx 0, busy 0, done 0, rd_valid 0, rd_data 0, state IDLE.
- Reset mid-load returns to IDLE and discards the count. RAM keeps its contents.

## Timing
- Write latency: a word accepted at edge N is readable by an rd_en issued in cycle N+1, with data returned at N+2.
- Full load takes at least DEPTH cycles after the start edge. done rises on the edge of the final transfer.
- busy = (state == LOAD), registered.
- Read latency is exactly 1 cycle, with back-to-back reads at full rate.

## Configuration
- BF_SBOX_WR_BYPASS_EN defined: when rd_en and a write transfer target the same index in the same cycle, rd_data returns wr_data (new data).
- BF_SBOX_WR_BYPASS_EN undefined: the same case returns the pre-write RAM content. No bypass mux is built.

## Structure
- Shared package bf_pkg holds:
  - BF_WORD_W = 32, BF_IDX_W = 8, BF_SBOX_DEPTH = 256
  - the loader state enum (IDLE/LOAD/DONE)
  - typedefs bf_word_t and bf_idx_t
- Sub-module bf_sbox_ram: DEPTH×DATA_W array with one synchronous write port, one registered read port, and the optional bypass.
- The top module holds the FSM, the counter and the handshake.

## Test plan
- Full load: reset, start, stream words 32'h00000000+i for i = 0..255 with wr_valid held high. Expect done at 256 cycles after start. Read indices 0, 1, 255 → 32'h00000000, 32'h00000001, 32'h000000FF, each one cycle after rd_en.
- Backpressure: toggle wr_valid 1/0 every cycle. Expect done after 512 cycles, wr_idx stepping only on valid cycles, and correct contents.
- Ignored restart: start at wr_idx = 100 during LOAD. Expect the load to continue to 255, with done only after 256 total transfers.
- Reset mid-load: deassert rst_n at wr_idx = 50. Expect state IDLE and all outputs at reset values. A new start reloads from index 0.
- Read/write collision: write 32'hDEADBEEF to index 7 while reading index 7 (old value 32'h00000007). Expect rd_data = 32'h00000007 without BF_SBOX_WR_BYPASS_EN, and 32'hDEADBEEF with it.
- Reload from DONE: start again and stream ~i. Expect done to clear on start, re-assert after 256 transfers, and index 3 to read 32'hFFFFFFFC.
